hvac_actuator_driver: RTL and testbench
=======================================

Name: hvac_actuator_driver

Overview:
- Downstream stage of the air-conditioning controller.
- Consumes the controller's 2-bit {heating, cooling} request and drives the physical heater, cooler and fan enables.
- Enforces compressor/element protection: minimum on-time, minimum off-time (lockout) between any two runs, and fan post-run after every run.
- Guarantees heater and cooler are never enabled together, including during a direct heat<->cool request change.

Parameters:
- MIN_ON, 8, minimum cycles heater_en/cooler_en stay high once asserted (>=1).
- MIN_OFF, 8, lockout cycles with both actuators off after any run ends (>=1).
- FAN_POST, 4, cycles fan_en stays high at the start of lockout (0..MIN_OFF).
- CNT_W, 8, timer width; MIN_ON and MIN_OFF must each be <= 2^CNT_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- request  input  2  {heating, cooling} from the controller: 10 = heat, 01 = cool, 00 = idle, 11 = illegal.
- heater_en  output  1  heater actuator enable.
- cooler_en  output  1  cooler actuator enable.
- fan_en  output  1  fan enable.
- busy  output  1  protection timer active; the request cannot currently be honoured immediately.
- fault  output  1  sticky; set when request==11 is sampled.

Behaviour:
- Reset
  - Asserting rst_n low immediately forces state=IDLE, timer=0 and heater_en=cooler_en=fan_en=busy=fault=0. All outputs are registered flops with async clear.
  - Reset mid-run drops the enables at once; no lockout is enforced after reset is released.
- State machine: IDLE, HEAT_ON, COOL_ON, LOCKOUT. Outputs are Moore, decoded from registered state and timer.
- IDLE (all enables 0)
  - request==10 -> HEAT_ON; request==01 -> COOL_ON; the timer loads MIN_ON-1 on entry.
  - request 00 or 11 -> stay in IDLE.
  - Latency: enable rises on the first edge that samples the request in IDLE.
- HEAT_ON (heater_en=1, fan_en=1)
  - timer!=0: decrement and stay, regardless of request.
  - timer==0 and request!=10: go to LOCKOUT and load MIN_OFF-1.
  - timer==0 and request==10: stay; timer holds at 0 (saturates, no wrap).
- COOL_ON: identical to HEAT_ON, with cooler_en and request==01.
- LOCKOUT (heater_en=cooler_en=0)
  - Timer decrements each cycle.
  - At timer==0, go to IDLE unconditionally. The request is re-evaluated only in IDLE.
  - fan_en=1 while timer >= MIN_OFF-FAN_POST, i.e. for the first FAN_POST lockout cycles. FAN_POST=0 means no post-run.
- Timing guarantees
  - Minimum enable pulse = MIN_ON cycles.
  - Minimum gap between one enable falling and any enable rising = MIN_OFF+1 cycles (MIN_OFF lockout cycles + 1 IDLE cycle).
- Direct switch (request 10->01 during HEAT_ON)
  - Finish min-on, then LOCKOUT, then IDLE, then COOL_ON.
  - heater_en and cooler_en are never simultaneously 1 in any cycle.
- busy = 1 in LOCKOUT, or in HEAT_ON/COOL_ON while timer!=0. Otherwise 0.
- Illegal request 11
  - Treated as 00 for all transitions.
  - fault goes to 1 on the sampling edge and stays high until reset.
- Request changes during min-on or lockout are ignored; no queuing of requests.

Test Plan:
- Defaults; reset, then request=10 held for 3 cycles, then 00 -> heater_en rises 1 cycle after first sample and is high exactly 8 cycles; busy high 7 of those and through lockout; fan_en stays high 4 cycles after heater_en falls; IDLE reached 8 cycles after fall.
- Request=01 held 20 cycles -> cooler_en high 20 cycles (timer saturated at 0); drops the cycle after request=00 is sampled; lockout 8 cycles, fan 4 cycles.
- HEAT_ON then request switched to 01 at cycle 2 -> heater high 8 cycles, both enables low for 9 cycles, then cooler_en rises; assert heater_en&cooler_en never 1.
- During LOCKOUT, request toggles 10/01 -> no enable asserted until IDLE; then the current request is honoured next edge.
- Request=11 for 1 cycle in IDLE -> no enable, fault=1 and still 1 after 50 cycles of legal traffic; cleared only by rst_n.
- rst_n pulsed low mid-HEAT_ON (timer=5) -> heater_en/fan_en/busy drop asynchronously before next clk edge; after release with request=10, heater_en rises on the first edge (no lockout).

Source files
------------

// File: rtl/hvac_actuator_driver_if.sv
// Request/actuator bundle between the HVAC controller and the actuator driver.
// The controller drives the request; the driver drives enables and status.
interface hvac_actuator_driver_if;
  logic [1:0] request;
  logic       heater_en;
  logic       cooler_en;
  logic       fan_en;
  logic       busy;
  logic       fault;

  modport master (
    output request,
    input  heater_en, cooler_en, fan_en, busy, fault
  );

  modport slave (
    input  request,
    output heater_en, cooler_en, fan_en, busy, fault
  );
endinterface

// File: rtl/hvac_actuator_driver.sv
// Heater/cooler/fan driver with minimum on-time, post-run lockout and fan post-run.
// Heater and cooler are mutually exclusive by construction: a run always passes through LOCKOUT and IDLE.
module hvac_actuator_driver #(
  parameter int unsigned MIN_ON   = 8,
  parameter int unsigned MIN_OFF  = 8,
  parameter int unsigned FAN_POST = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hvac_actuator_driver_if.slave act_if
);

  localparam logic [1:0]        REQ_HEAT = 2'b10;
  localparam logic [1:0]        REQ_COOL = 2'b01;
  localparam logic [1:0]        REQ_ILL  = 2'b11;
  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(MIN_OFF - 1);
  localparam int unsigned       FAN_TH   = MIN_OFF - FAN_POST;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAT_ON,
    ST_COOL_ON,
    ST_LOCKOUT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              heater_q, heater_d;
  logic              cooler_q, cooler_d;
  logic              fan_q, fan_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic              running_d;

  // Next state/timer, plus Moore outputs decoded from the next state so they land in flops.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    fault_d   = fault_q | (act_if.request == REQ_ILL);

    case (state_q)
      ST_IDLE: begin
        if (act_if.request == REQ_HEAT) begin
          state_d = ST_HEAT_ON;
          timer_d = ON_LOAD;
        end else if (act_if.request == REQ_COOL) begin
          state_d = ST_COOL_ON;
          timer_d = ON_LOAD;
        end
      end
      ST_HEAT_ON: begin
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (act_if.request != REQ_HEAT) begin
          state_d = ST_LOCKOUT;
          timer_d = OFF_LOAD;
        end
      end
      ST_COOL_ON: begin
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (act_if.request != REQ_COOL) begin
          state_d = ST_LOCKOUT;
          timer_d = OFF_LOAD;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    heater_d  = (state_d == ST_HEAT_ON);
    cooler_d  = (state_d == ST_COOL_ON);
    running_d = heater_d | cooler_d;
    // Post-run fan covers the first FAN_POST lockout cycles (timer counts down from MIN_OFF-1).
    fan_d     = running_d | ((state_d == ST_LOCKOUT) && (32'(timer_d) >= FAN_TH));
    busy_d    = (state_d == ST_LOCKOUT) | (running_d && (timer_d != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      heater_q <= 1'b0;
      cooler_q <= 1'b0;
      fan_q    <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      heater_q <= heater_d;
      cooler_q <= cooler_d;
      fan_q    <= fan_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign act_if.heater_en = heater_q;
  assign act_if.cooler_en = cooler_q;
  assign act_if.fan_en    = fan_q;
  assign act_if.busy      = busy_q;
  assign act_if.fault     = fault_q;

endmodule

// File: tb/tb_hvac_actuator_driver.sv
// Self-checking bench for hvac_actuator_driver: directed scenarios plus randomized traffic
// compared every cycle against an age-counting behavioural model.
module tb_hvac_actuator_driver;

  localparam int unsigned MIN_ON   = 8;
  localparam int unsigned MIN_OFF  = 8;
  localparam int unsigned FAN_POST = 4;
  localparam int unsigned CNT_W    = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;

  hvac_actuator_driver_if dif ();

  hvac_actuator_driver #(
    .MIN_ON   (MIN_ON),
    .MIN_OFF  (MIN_OFF),
    .FAN_POST (FAN_POST),
    .CNT_W    (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .act_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 heating, 2 cooling, 3 lockout; ages count cycles spent in a run / lockout.
  int m_mode;
  int m_age;
  int m_lock_age;
  bit m_fault;

  task automatic model_reset();
    m_mode     = 0;
    m_age      = 0;
    m_lock_age = 0;
    m_fault    = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] r);
    int want;
    if (r == 2'b11) m_fault = 1'b1;
    case (m_mode)
      0: begin
        if (r == 2'b10) begin m_mode = 1; m_age = 1; end
        else if (r == 2'b01) begin m_mode = 2; m_age = 1; end
      end
      1, 2: begin
        want = (m_mode == 1) ? 2 : 1;
        if (m_age < int'(MIN_ON)) m_age++;
        else if (int'(r) != want) begin m_mode = 3; m_lock_age = 1; end
      end
      default: begin
        if (m_lock_age < int'(MIN_OFF)) m_lock_age++;
        else m_mode = 0;
      end
    endcase
  endtask

  function automatic logic [4:0] exp_vec();
    logic h, c, f, b;
    h = (m_mode == 1);
    c = (m_mode == 2);
    f = h | c | ((m_mode == 3) && (m_lock_age <= int'(FAN_POST)));
    b = (m_mode == 3) | ((h | c) && (m_age < int'(MIN_ON)));
    return {h, c, f, b, m_fault};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {dif.heater_en, dif.cooler_en, dif.fan_en, dif.busy, dif.fault};
  endfunction

  // Drive one request across one rising edge; returns at the following falling edge.
  task automatic tick(input logic [1:0] r);
    dif.request = r;
    @(posedge clk);
    model_step(r);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dif.request = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (obs_vec() !== 5'b00000) begin
      fails++;
      $display("FAIL reset_state got=%b exp=%b", obs_vec(), 5'b00000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_heat_min_on();
    int hcnt, bcnt, fpost;
    logic [4:0] o, e;
    hcnt = 0; bcnt = 0; fpost = 0;
    for (int i = 0; i < 25; i++) begin
      tick((i < 3) ? 2'b10 : 2'b00);
      o = obs_vec(); e = exp_vec();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL heat_model cyc=%0d got=%b exp=%b", cyc, o, e);
      end
      if (i == 0) begin
        tests++;
        if (dif.heater_en !== 1'b1) begin
          fails++;
          $display("FAIL heat_first_edge got=%b exp=1", dif.heater_en);
        end
      end
      if (dif.heater_en) hcnt++;
      if (dif.busy) bcnt++;
      if (dif.fan_en && !dif.heater_en) fpost++;
    end
    tests++;
    if (hcnt != int'(MIN_ON)) begin
      fails++;
      $display("FAIL heat_on_cycles got=%0d exp=%0d", hcnt, MIN_ON);
    end
    tests++;
    if (bcnt != int'(MIN_ON - 1 + MIN_OFF)) begin
      fails++;
      $display("FAIL heat_busy_cycles got=%0d exp=%0d", bcnt, MIN_ON - 1 + MIN_OFF);
    end
    tests++;
    if (fpost != int'(FAN_POST)) begin
      fails++;
      $display("FAIL heat_fan_post got=%0d exp=%0d", fpost, FAN_POST);
    end
  endtask

  task automatic test_cool_hold();
    int ccnt, fpost;
    logic [4:0] o, e;
    ccnt = 0; fpost = 0;
    for (int i = 0; i < 40; i++) begin
      tick((i < 20) ? 2'b01 : 2'b00);
      o = obs_vec(); e = exp_vec();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL cool_model cyc=%0d got=%b exp=%b", cyc, o, e);
      end
      if (dif.cooler_en) ccnt++;
      if (dif.fan_en && !dif.cooler_en) fpost++;
    end
    tests++;
    if (ccnt != 20) begin
      fails++;
      $display("FAIL cool_hold_cycles got=%0d exp=20", ccnt);
    end
    tests++;
    if (fpost != int'(FAN_POST)) begin
      fails++;
      $display("FAIL cool_fan_post got=%0d exp=%0d", fpost, FAN_POST);
    end
  endtask

  task automatic test_direct_switch();
    int hcnt, gap, overlap;
    bit fell, rose;
    logic [4:0] o, e;
    hcnt = 0; gap = 0; overlap = 0; fell = 0; rose = 0;
    for (int i = 0; i < 30; i++) begin
      tick((i < 2) ? 2'b10 : 2'b01);
      o = obs_vec(); e = exp_vec();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL switch_model cyc=%0d got=%b exp=%b", cyc, o, e);
      end
      if (dif.heater_en && dif.cooler_en) overlap++;
      if (dif.heater_en) hcnt++;
      else if (hcnt > 0) fell = 1;
      if (dif.cooler_en) rose = 1;
      if (fell && !rose && !dif.heater_en && !dif.cooler_en) gap++;
    end
    tests++;
    if (hcnt != int'(MIN_ON)) begin
      fails++;
      $display("FAIL switch_heat_cycles got=%0d exp=%0d", hcnt, MIN_ON);
    end
    tests++;
    if (!rose || gap != int'(MIN_OFF + 1)) begin
      fails++;
      $display("FAIL switch_gap got=%0d rose=%0d exp=%0d", gap, rose, MIN_OFF + 1);
    end
    tests++;
    if (overlap != 0) begin
      fails++;
      $display("FAIL switch_overlap got=%0d exp=0", overlap);
    end
    for (int i = 0; i < 25; i++) tick(2'b00);
  endtask

  task automatic test_lockout_toggle();
    int en_seen;
    logic [4:0] o, e;
    en_seen = 0;
    tick(2'b10);
    for (int i = 0; i < int'(MIN_ON); i++) tick(2'b00);
    for (int i = 0; i < int'(MIN_OFF) - 1; i++) begin
      tick((i % 2 == 0) ? 2'b10 : 2'b01);
      if (dif.heater_en || dif.cooler_en) en_seen++;
      o = obs_vec(); e = exp_vec();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL lockout_model cyc=%0d got=%b exp=%b", cyc, o, e);
      end
    end
    tests++;
    if (en_seen != 0) begin
      fails++;
      $display("FAIL lockout_enable got=%0d exp=0", en_seen);
    end
    tick(2'b01);
    tests++;
    if ({dif.heater_en, dif.cooler_en, dif.busy} !== 3'b000) begin
      fails++;
      $display("FAIL lockout_to_idle got=%b exp=000", {dif.heater_en, dif.cooler_en, dif.busy});
    end
    tick(2'b10);
    tests++;
    if ({dif.heater_en, dif.cooler_en} !== 2'b10) begin
      fails++;
      $display("FAIL lockout_honour got=%b exp=10", {dif.heater_en, dif.cooler_en});
    end
    for (int i = 0; i < 25; i++) tick(2'b00);
  endtask

  task automatic test_reset_mid_run();
    repeat (3) tick(2'b10);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({dif.heater_en, dif.fan_en, dif.busy} !== 3'b000) begin
      fails++;
      $display("FAIL async_reset got=%b exp=000", {dif.heater_en, dif.fan_en, dif.busy});
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    tick(2'b10);
    tests++;
    if (obs_vec() !== 5'b10110) begin
      fails++;
      $display("FAIL reset_no_lockout got=%b exp=%b", obs_vec(), 5'b10110);
    end
    for (int i = 0; i < 25; i++) tick(2'b00);
  endtask

  task automatic test_fault();
    logic [4:0] o, e;
    logic [1:0] r;
    tick(2'b11);
    tests++;
    if (obs_vec() !== 5'b00001) begin
      fails++;
      $display("FAIL fault_set got=%b exp=%b", obs_vec(), 5'b00001);
    end
    for (int i = 0; i < 50; i++) begin
      r = 2'($urandom_range(0, 2));
      tick(r);
      o = obs_vec(); e = exp_vec();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL fault_traffic cyc=%0d got=%b exp=%b", cyc, o, e);
      end
    end
    tests++;
    if (dif.fault !== 1'b1) begin
      fails++;
      $display("FAIL fault_sticky got=%b exp=1", dif.fault);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs_vec() !== 5'b00000) begin
      fails++;
      $display("FAIL fault_clear got=%b exp=%b", obs_vec(), 5'b00000);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] o, e;
    logic [1:0] r;
    int hold;
    int n;
    n = 0;
    while (n < 400) begin
      r    = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      hold = int'($urandom_range(1, 12));
      for (int k = 0; k < hold; k++) begin
        tick(r);
        n++;
        o = obs_vec(); e = exp_vec();
        tests++;
        if (o !== e || (dif.heater_en && dif.cooler_en)) begin
          fails++;
          $display("FAIL random_model cyc=%0d req=%b got=%b exp=%b", cyc, r, o, e);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst_n = 1'b0;
    dif.request = 2'b00;
    test_reset();
    test_heat_min_on();
    test_cool_hold();
    test_direct_switch();
    test_lockout_toggle();
    test_reset_mid_run();
    test_fault();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
